// File: rtl/exception_ctrl_if.sv
// Bundle of the MEM-stage exception inputs and the CP0 exception report
// outputs. The slave modport is the exception controller's view; the master
// modport is the view of whoever drives the pipeline side and consumes the
// report.
interface exception_ctrl_if;
  logic        stall_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic        fetch_adel_i;
  logic        ri_i;
  logic        ov_i;
  logic        syscall_i;
  logic        break_i;
  logic        load_adel_i;
  logic        store_ades_i;
  logic        eret_i;
  logic [31:0] mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  modport slave (
    input  stall_i, valid_i, pc_i, in_delayslot_i,
    input  fetch_adel_i, ri_i, ov_i, syscall_i, break_i,
    input  load_adel_i, store_ades_i, eret_i, mem_addr_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output bad_addr_o, flush_o, newpc_o
  );

  modport master (
    output stall_i, valid_i, pc_i, in_delayslot_i,
    output fetch_adel_i, ri_i, ov_i, syscall_i, break_i,
    output load_adel_i, store_ades_i, eret_i, mem_addr_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  bad_addr_o, flush_o, newpc_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception detector/reporter. Picks the highest-priority event,
// presents it to CP0 as a one-shot, stall-stable report together with the
// pipeline flush and redirect PC, then sits out one shadow cycle so a second
// exception cannot be reported before Status.EXL is visible.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input logic            clk,
  input logic            rst,
  exception_ctrl_if.slave exc
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPORT = 2'd1,
    ST_SHADOW = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_code;
  logic [31:0] r_inst_addr;
  logic        r_delayslot;
  logic [31:0] r_bad_addr;
  logic        r_flush;
  logic [31:0] r_newpc;

  logic [4:0]  w_code_nxt;
  logic [31:0] w_inst_addr_nxt;
  logic        w_delayslot_nxt;
  logic [31:0] w_bad_addr_nxt;
  logic        w_flush_nxt;
  logic [31:0] w_newpc_nxt;

  logic        w_int_pending;
  logic [4:0]  w_code;
  logic [31:0] w_bad;
  logic        w_is_eret;
  logic        w_detect;
  logic        w_unused;

  // Interrupt needs an enabled pending line, IE=1 and EXL=0.
  assign w_int_pending = (|(exc.cp0_cause_i[15:8] & exc.cp0_status_i[15:8]))
                         & exc.cp0_status_i[0] & ~exc.cp0_status_i[1];

  // Bits of the CP0 words this block never looks at.
  assign w_unused = &{1'b0, exc.cp0_status_i[31:16], exc.cp0_status_i[7:2],
                      exc.cp0_cause_i[31:16], exc.cp0_cause_i[7:0]};

  // Fixed-priority selection of the single event to report.
  always_comb begin
    w_code    = 5'd0;
    w_bad     = 32'd0;
    w_is_eret = 1'b0;
    if (w_int_pending) begin
      w_code = 5'h01;
    end else if (exc.fetch_adel_i) begin
      w_code = 5'h04;
      w_bad  = exc.pc_i;
    end else if (exc.ri_i) begin
      w_code = 5'h0A;
    end else if (exc.ov_i) begin
      w_code = 5'h0C;
    end else if (exc.syscall_i) begin
      w_code = 5'h08;
    end else if (exc.break_i) begin
      w_code = 5'h09;
    end else if (exc.load_adel_i) begin
      w_code = 5'h04;
      w_bad  = exc.mem_addr_i;
    end else if (exc.store_ades_i) begin
      w_code = 5'h05;
      w_bad  = exc.mem_addr_i;
    end else if (exc.eret_i) begin
      w_code    = 5'h0E;
      w_is_eret = 1'b1;
    end else begin
      w_code = 5'd0;
    end
  end

  // Only a real instruction can carry an event (interrupts too, so EPC is valid).
  assign w_detect = exc.valid_i & (w_code != 5'd0);

  // Next-state and next-output logic; a stall freezes everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_inst_addr_nxt = r_inst_addr;
    w_delayslot_nxt = r_delayslot;
    w_bad_addr_nxt  = r_bad_addr;
    w_flush_nxt     = r_flush;
    w_newpc_nxt     = r_newpc;
    if (exc.stall_i) begin
      w_state_nxt = r_state;
    end else begin
      w_code_nxt      = 5'd0;
      w_inst_addr_nxt = 32'd0;
      w_delayslot_nxt = 1'b0;
      w_bad_addr_nxt  = 32'd0;
      w_flush_nxt     = 1'b0;
      w_newpc_nxt     = 32'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_detect) begin
            w_state_nxt     = ST_REPORT;
            w_code_nxt      = w_code;
            w_inst_addr_nxt = exc.pc_i;
            w_delayslot_nxt = exc.in_delayslot_i;
            w_bad_addr_nxt  = w_bad;
            w_flush_nxt     = 1'b1;
            w_newpc_nxt     = w_is_eret ? exc.cp0_epc_i : EXC_VECTOR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_REPORT: w_state_nxt = ST_SHADOW;
        ST_SHADOW: w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and report registers; reset wins over stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_code      <= 5'd0;
      r_inst_addr <= 32'd0;
      r_delayslot <= 1'b0;
      r_bad_addr  <= 32'd0;
      r_flush     <= 1'b0;
      r_newpc     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_delayslot <= w_delayslot_nxt;
      r_bad_addr  <= w_bad_addr_nxt;
      r_flush     <= w_flush_nxt;
      r_newpc     <= w_newpc_nxt;
    end
  end

  assign exc.excepttype_o        = {27'd0, r_code};
  assign exc.current_inst_addr_o = r_inst_addr;
  assign exc.is_in_delayslot_o   = r_delayslot;
  assign exc.bad_addr_o          = r_bad_addr;
  assign exc.flush_o             = r_flush;
  assign exc.newpc_o             = r_newpc;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: each task drives one scenario and
// compares outputs against hand-computed values one time unit after the edge.
module tb_exception_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exception_ctrl_if u_if ();

  exception_ctrl dut (
    .clk (clk),
    .rst (rst),
    .exc (u_if.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    u_if.stall_i        = 1'b0;
    u_if.valid_i        = 1'b0;
    u_if.pc_i           = 32'd0;
    u_if.in_delayslot_i = 1'b0;
    u_if.fetch_adel_i   = 1'b0;
    u_if.ri_i           = 1'b0;
    u_if.ov_i           = 1'b0;
    u_if.syscall_i      = 1'b0;
    u_if.break_i        = 1'b0;
    u_if.load_adel_i    = 1'b0;
    u_if.store_ades_i   = 1'b0;
    u_if.eret_i         = 1'b0;
    u_if.mem_addr_i     = 32'd0;
    u_if.cp0_status_i   = 32'd0;
    u_if.cp0_cause_i    = 32'd0;
    u_if.cp0_epc_i      = 32'd0;
  endtask

  // Return to IDLE: one edge to SHADOW, one edge back to IDLE.
  task automatic drain();
    clr_inputs();
    step();
    step();
  endtask

  task automatic test_reset();
    clr_inputs();
    u_if.valid_i   = 1'b1;
    u_if.syscall_i = 1'b1;
    rst = 1'b0;
    step();
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL reset_type got %h exp %h", u_if.excepttype_o, 32'd0); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", u_if.flush_o); end
    checks++; if (u_if.newpc_o !== 32'd0) begin errors++; $display("FAIL reset_newpc got %h exp 0", u_if.newpc_o); end
    checks++; if (u_if.current_inst_addr_o !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", u_if.current_inst_addr_o); end
    checks++; if (u_if.bad_addr_o !== 32'd0) begin errors++; $display("FAIL reset_bad got %h exp 0", u_if.bad_addr_o); end
    checks++; if (u_if.is_in_delayslot_o !== 1'b0) begin errors++; $display("FAIL reset_ds got %b exp 0", u_if.is_in_delayslot_o); end
    clr_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_syscall();
    clr_inputs();
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'hBFC00100;
    u_if.syscall_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'h8) begin errors++; $display("FAIL sys_type got %h exp %h", u_if.excepttype_o, 32'h8); end
    checks++; if (u_if.current_inst_addr_o !== 32'hBFC00100) begin errors++; $display("FAIL sys_pc got %h exp BFC00100", u_if.current_inst_addr_o); end
    checks++; if (u_if.flush_o !== 1'b1) begin errors++; $display("FAIL sys_flush got %b exp 1", u_if.flush_o); end
    checks++; if (u_if.newpc_o !== 32'hBFC00380) begin errors++; $display("FAIL sys_newpc got %h exp BFC00380", u_if.newpc_o); end
    checks++; if (u_if.is_in_delayslot_o !== 1'b0) begin errors++; $display("FAIL sys_ds got %b exp 0", u_if.is_in_delayslot_o); end
    checks++; if (u_if.bad_addr_o !== 32'd0) begin errors++; $display("FAIL sys_bad got %h exp 0", u_if.bad_addr_o); end
    // flag kept high: the report must still be one-shot, then SHADOW ignores it
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL sys_shadow_type got %h exp 0", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL sys_shadow_flush got %b exp 0", u_if.flush_o); end
    checks++; if (u_if.newpc_o !== 32'd0) begin errors++; $display("FAIL sys_shadow_newpc got %h exp 0", u_if.newpc_o); end
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL sys_idle_type got %h exp 0", u_if.excepttype_o); end
    clr_inputs();
    step();
  endtask

  task automatic test_priority();
    clr_inputs();
    u_if.valid_i      = 1'b1;
    u_if.pc_i         = 32'h80000040;
    u_if.ov_i         = 1'b1;
    u_if.store_ades_i = 1'b1;
    u_if.mem_addr_i   = 32'h80000003;
    step();
    checks++; if (u_if.excepttype_o !== 32'hC) begin errors++; $display("FAIL ov_type got %h exp %h", u_if.excepttype_o, 32'hC); end
    checks++; if (u_if.bad_addr_o !== 32'd0) begin errors++; $display("FAIL ov_bad got %h exp 0", u_if.bad_addr_o); end
    drain();
    u_if.valid_i      = 1'b1;
    u_if.pc_i         = 32'h80000044;
    u_if.store_ades_i = 1'b1;
    u_if.mem_addr_i   = 32'h80000003;
    step();
    checks++; if (u_if.excepttype_o !== 32'h5) begin errors++; $display("FAIL ades_type got %h exp %h", u_if.excepttype_o, 32'h5); end
    checks++; if (u_if.bad_addr_o !== 32'h80000003) begin errors++; $display("FAIL ades_bad got %h exp 80000003", u_if.bad_addr_o); end
    checks++; if (u_if.current_inst_addr_o !== 32'h80000044) begin errors++; $display("FAIL ades_pc got %h exp 80000044", u_if.current_inst_addr_o); end
    drain();
    // fetch_adel beats ri; bad address is the PC
    u_if.valid_i      = 1'b1;
    u_if.pc_i         = 32'h80000049;
    u_if.fetch_adel_i = 1'b1;
    u_if.ri_i         = 1'b1;
    u_if.mem_addr_i   = 32'h11111111;
    step();
    checks++; if (u_if.excepttype_o !== 32'h4) begin errors++; $display("FAIL fadel_type got %h exp 4", u_if.excepttype_o); end
    checks++; if (u_if.bad_addr_o !== 32'h80000049) begin errors++; $display("FAIL fadel_bad got %h exp 80000049", u_if.bad_addr_o); end
    drain();
    // flags without a valid instruction are not reported
    u_if.syscall_i = 1'b1;
    u_if.ri_i      = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL novalid_type got %h exp 0", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL novalid_flush got %b exp 0", u_if.flush_o); end
    clr_inputs();
    step();
  endtask

  task automatic test_interrupt();
    clr_inputs();
    u_if.valid_i      = 1'b1;
    u_if.pc_i         = 32'h80000010;
    u_if.cp0_status_i = 32'h00000401;
    u_if.cp0_cause_i  = 32'h00000400;
    u_if.load_adel_i  = 1'b1;
    u_if.mem_addr_i   = 32'h12345678;
    step();
    checks++; if (u_if.excepttype_o !== 32'h1) begin errors++; $display("FAIL int_type got %h exp 1", u_if.excepttype_o); end
    checks++; if (u_if.bad_addr_o !== 32'd0) begin errors++; $display("FAIL int_bad got %h exp 0", u_if.bad_addr_o); end
    checks++; if (u_if.current_inst_addr_o !== 32'h80000010) begin errors++; $display("FAIL int_pc got %h exp 80000010", u_if.current_inst_addr_o); end
    checks++; if (u_if.newpc_o !== 32'hBFC00380) begin errors++; $display("FAIL int_newpc got %h exp BFC00380", u_if.newpc_o); end
    drain();
    u_if.valid_i      = 1'b1;
    u_if.pc_i         = 32'h80000010;
    u_if.cp0_status_i = 32'h00000403;
    u_if.cp0_cause_i  = 32'h00000400;
    u_if.load_adel_i  = 1'b1;
    u_if.mem_addr_i   = 32'h12345678;
    step();
    checks++; if (u_if.excepttype_o !== 32'h4) begin errors++; $display("FAIL exl_type got %h exp 4", u_if.excepttype_o); end
    checks++; if (u_if.bad_addr_o !== 32'h12345678) begin errors++; $display("FAIL exl_bad got %h exp 12345678", u_if.bad_addr_o); end
    drain();
  endtask

  task automatic test_stall_hold();
    clr_inputs();
    u_if.valid_i = 1'b1;
    u_if.pc_i    = 32'h80000100;
    u_if.break_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'h9) begin errors++; $display("FAIL brk_type got %h exp 9", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b1) begin errors++; $display("FAIL brk_flush got %b exp 1", u_if.flush_o); end
    u_if.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (u_if.excepttype_o !== 32'h9) begin errors++; $display("FAIL stall_type[%0d] got %h exp 9", i, u_if.excepttype_o); end
      checks++; if (u_if.flush_o !== 1'b1) begin errors++; $display("FAIL stall_flush[%0d] got %b exp 1", i, u_if.flush_o); end
      checks++; if (u_if.current_inst_addr_o !== 32'h80000100) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 80000100", i, u_if.current_inst_addr_o); end
    end
    clr_inputs();
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL unstall_type got %h exp 0", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL unstall_flush got %b exp 0", u_if.flush_o); end
    step();
  endtask

  task automatic test_eret();
    clr_inputs();
    u_if.valid_i        = 1'b1;
    u_if.pc_i           = 32'h80000020;
    u_if.eret_i         = 1'b1;
    u_if.cp0_epc_i      = 32'h80001234;
    u_if.in_delayslot_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'hE) begin errors++; $display("FAIL eret_type got %h exp E", u_if.excepttype_o); end
    checks++; if (u_if.newpc_o !== 32'h80001234) begin errors++; $display("FAIL eret_newpc got %h exp 80001234", u_if.newpc_o); end
    checks++; if (u_if.is_in_delayslot_o !== 1'b1) begin errors++; $display("FAIL eret_ds got %b exp 1", u_if.is_in_delayslot_o); end
    clr_inputs();
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL eret_shadow got %h exp 0", u_if.excepttype_o); end
    // a new flag arrives while in SHADOW and must be dropped
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h80000024;
    u_if.syscall_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL shadow_drop_type got %h exp 0", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL shadow_drop_flush got %b exp 0", u_if.flush_o); end
    clr_inputs();
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL shadow_after got %h exp 0", u_if.excepttype_o); end
  endtask

  task automatic test_reset_mid_report();
    clr_inputs();
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h80000200;
    u_if.syscall_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'h8) begin errors++; $display("FAIL rmid_pre got %h exp 8", u_if.excepttype_o); end
    clr_inputs();
    u_if.stall_i = 1'b1;
    rst = 1'b0;
    step();
    checks++; if (u_if.excepttype_o !== 32'd0) begin errors++; $display("FAIL rmid_type got %h exp 0", u_if.excepttype_o); end
    checks++; if (u_if.flush_o !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b exp 0", u_if.flush_o); end
    checks++; if (u_if.newpc_o !== 32'd0) begin errors++; $display("FAIL rmid_newpc got %h exp 0", u_if.newpc_o); end
    checks++; if (u_if.current_inst_addr_o !== 32'd0) begin errors++; $display("FAIL rmid_pc got %h exp 0", u_if.current_inst_addr_o); end
    rst          = 1'b1;
    u_if.stall_i = 1'b0;
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h80000300;
    u_if.syscall_i = 1'b1;
    step();
    checks++; if (u_if.excepttype_o !== 32'h8) begin errors++; $display("FAIL rpost_type got %h exp 8", u_if.excepttype_o); end
    checks++; if (u_if.current_inst_addr_o !== 32'h80000300) begin errors++; $display("FAIL rpost_pc got %h exp 80000300", u_if.current_inst_addr_o); end
    checks++; if (u_if.flush_o !== 1'b1) begin errors++; $display("FAIL rpost_flush got %b exp 1", u_if.flush_o); end
    drain();
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clr_inputs();
    test_reset();
    test_syscall();
    test_priority();
    test_interrupt();
    test_stall_hold();
    test_eret();
    test_reset_mid_report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
